// File: rtl/demux_1_4_32_reg_if.sv
// ---------------------------------------------------------------------------
// demux_1_4_32_reg_if
//   Bundle of the producer-side and consumer-side handshake/bus signals of the
//   registered 1-to-4 word distributor.
//
//   Producer side : data_in, select, enable, in_valid  -> block
//                   in_ready                           <- block
//   Consumer side : data_0..3, valid_0..3              <- block
//                   ready_0..3                         -> block
//
//   Modports
//     slave  : the distributor itself
//     master : the environment (producer plus the four consumers)
// ---------------------------------------------------------------------------
interface demux_1_4_32_reg_if #(
   parameter int WIDTH = 32
);
   // producer side
   logic [WIDTH-1:0] data_in;
   logic [1:0]       select;
   logic             enable;
   logic             in_valid;
   logic             in_ready;

   // consumer side
   logic [WIDTH-1:0] data_0;
   logic [WIDTH-1:0] data_1;
   logic [WIDTH-1:0] data_2;
   logic [WIDTH-1:0] data_3;
   logic             valid_0;
   logic             valid_1;
   logic             valid_2;
   logic             valid_3;
   logic             ready_0;
   logic             ready_1;
   logic             ready_2;
   logic             ready_3;

   modport slave (
      input  data_in, select, enable, in_valid,
      output in_ready,
      output data_0, data_1, data_2, data_3,
      output valid_0, valid_1, valid_2, valid_3,
      input  ready_0, ready_1, ready_2, ready_3
   );

   modport master (
      output data_in, select, enable, in_valid,
      input  in_ready,
      input  data_0, data_1, data_2, data_3,
      input  valid_0, valid_1, valid_2, valid_3,
      output ready_0, ready_1, ready_2, ready_3
   );
endinterface

// File: rtl/demux_1_4_32_reg.sv
// ---------------------------------------------------------------------------
// demux_1_4_32_reg
//   Registered 1-to-4 word distributor. One WIDTH-bit word per cycle enters on
//   a valid/ready port and is steered into the one-entry buffer of the channel
//   named by select. Each channel holds its word until its consumer accepts it.
//
//   Ports
//     clock    : rising-edge clock, sole clock domain
//     reset_b  : asynchronous active-low reset
//     bus      : demux_1_4_32_reg_if.slave
//                  data_in/select/enable/in_valid -> in, in_ready <- out
//                  data_k/valid_k out, ready_k in   (k = 0..3)
//
//   Build option
//     DEMUX_TRISTATE_EN : when defined, data_k floats (Z) while channel k is
//                         empty so the channel can share a bus; when undefined
//                         data_k always shows the last word loaded (0 after
//                         reset). Handshake and timing are identical.
// ---------------------------------------------------------------------------
module demux_1_4_32_reg #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset_b,
   demux_1_4_32_reg_if.slave  bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_t;

   ch_state_t        state_q [4];
   ch_state_t        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [WIDTH-1:0] data_d  [4];

   logic [3:0]       ready_v;
   logic [3:0]       sel_oh;
   logic [3:0]       load_oh;
   logic             in_ready_w;
   logic             xfer_w;

   assign ready_v = {bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};

   // Select decode. A select carrying X/Z bits matches no item, lands in the
   // default branch and therefore addresses no channel: nothing is accepted.
   always_comb begin
      sel_oh = 4'b0000;
      case (bus.select)
         2'd0:    sel_oh = 4'b0001;
         2'd1:    sel_oh = 4'b0010;
         2'd2:    sel_oh = 4'b0100;
         2'd3:    sel_oh = 4'b1000;
         default: sel_oh = 4'b0000;
      endcase
   end

   // The selected channel can take a word if it is empty, or if it is being
   // drained in this same cycle (drain and reload, keeping 1 word/cycle).
   // Held low during reset so the producer never sees a false accept.
   always_comb begin
      in_ready_w = 1'b0;
      if (reset_b && bus.enable) begin
         for (int k = 0; k < 4; k++) begin
            if (sel_oh[k] && ((state_q[k] == EMPTY) || ready_v[k])) begin
               in_ready_w = 1'b1;
            end
         end
      end
   end

   assign xfer_w  = bus.in_valid & in_ready_w;
   assign load_oh = sel_oh & {4{xfer_w}};

   // Next state per channel: drain first, then a load overrides it so that a
   // simultaneous drain+load leaves the channel FULL with the new word.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         if ((state_q[k] == FULL) && ready_v[k]) begin
            state_d[k] = EMPTY;
         end
         if (load_oh[k]) begin
            state_d[k] = FULL;
            data_d[k]  = bus.data_in;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= EMPTY;
            data_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
         end
      end
   end

   assign bus.in_ready = in_ready_w;

   assign bus.valid_0  = (state_q[0] == FULL);
   assign bus.valid_1  = (state_q[1] == FULL);
   assign bus.valid_2  = (state_q[2] == FULL);
   assign bus.valid_3  = (state_q[3] == FULL);

`ifdef DEMUX_TRISTATE_EN
   assign bus.data_0 = (state_q[0] == FULL) ? data_q[0] : {WIDTH{1'bz}};
   assign bus.data_1 = (state_q[1] == FULL) ? data_q[1] : {WIDTH{1'bz}};
   assign bus.data_2 = (state_q[2] == FULL) ? data_q[2] : {WIDTH{1'bz}};
   assign bus.data_3 = (state_q[3] == FULL) ? data_q[3] : {WIDTH{1'bz}};
`else
   assign bus.data_0 = data_q[0];
   assign bus.data_1 = data_q[1];
   assign bus.data_2 = data_q[2];
   assign bus.data_3 = data_q[3];
`endif

endmodule

// File: tb/tb_demux_1_4_32_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1_4_32_reg
//   Directed bench for demux_1_4_32_reg. The producer task pushes each
//   accepted word onto the queue of its destination channel; a monitor
//   process pops and compares whenever a channel delivers (valid_k && ready_k).
//   Inputs change 1 time unit after the rising edge, outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_demux_1_4_32_reg;

   localparam int WIDTH = 32;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_q [4][$];

   demux_1_4_32_reg_if #(.WIDTH(WIDTH)) bus ();

   demux_1_4_32_reg #(.WIDTH(WIDTH)) dut (
      .clock   (clk),
      .reset_b (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]       valid_v;
   logic [3:0]       rdy_v;
   logic [WIDTH-1:0] data_v [4];

   assign valid_v   = {bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
   assign rdy_v     = {bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};
   assign data_v[0] = bus.data_0;
   assign data_v[1] = bus.data_1;
   assign data_v[2] = bus.data_2;
   assign data_v[3] = bus.data_3;

   // Value data_k shows while channel k is empty, given its register content.
   function automatic logic [WIDTH-1:0] idle(input logic [WIDTH-1:0] r);
`ifdef DEMUX_TRISTATE_EN
      idle = {WIDTH{1'bz}};
`else
      idle = r;
`endif
   endfunction

   task automatic chk(input string nm, input logic [WIDTH-1:0] act,
                      input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and hold it until accepted (bounded wait).
   task automatic send(input logic [WIDTH-1:0] w, input logic [1:0] s,
                       output int waited);
      bit done;
      done          = 1'b0;
      waited        = 0;
      bus.data_in   = w;
      bus.select    = s;
      bus.in_valid  = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q[s].push_back(w);
            done = 1'b1;
         end else begin
            waited++;
            if (waited > 20) begin
               checks++;
               errors++;
               $display("FAIL send_timeout: word %h sel %0d not accepted, got in_ready=0, required 1", w, s);
               done = 1'b1;
            end
         end
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [WIDTH-1:0] e;
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (valid_v[k] && rdy_v[k]) begin
               if (exp_q[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ch%0d_unexpected: got word %h, required no delivery", k, data_v[k]);
               end else begin
                  e = exp_q[k].pop_front();
                  chk($sformatf("ch%0d_data", k), data_v[k], e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   initial begin
      int w;
      bus.data_in  = '0;
      bus.select   = 2'd0;
      bus.enable   = 1'b1;
      bus.in_valid = 1'b1;
      bus.ready_0  = 1'b1;
      bus.ready_1  = 1'b1;
      bus.ready_2  = 1'b1;
      bus.ready_3  = 1'b1;
      rst_n        = 1'b1;

      // ---- reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", {28'd0, valid_v}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k), data_v[k], idle(32'd0));
      tick();
      tick();
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      tick();

      // ---- routing, one word per channel
      for (int k = 0; k < 4; k++) begin
         send(32'hA0A0_0000 + k, k[1:0], w);
         chk($sformatf("route_valid%0d", k), {31'd0, valid_v[k]}, 32'd1);
         chk($sformatf("route_word%0d", k), data_v[k], 32'hA0A0_0000 + k);
         for (int j = 0; j < 4; j++)
            if (j != k) chk($sformatf("route_other%0d_%0d", k, j), {31'd0, valid_v[j]}, 32'd0);
      end
      tick();

      // ---- backpressure on channel 2
      bus.ready_2 = 1'b0;
      send(32'h1111_1111, 2'd2, w);
      bus.data_in  = 32'h2222_2222;
      bus.select   = 2'd2;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_hold_data", data_v[2], 32'h1111_1111);
         chk("bp_hold_valid", {31'd0, valid_v[2]}, 32'd1);
         tick();
      end
      bus.ready_2 = 1'b1;
      send(32'h2222_2222, 2'd2, w);
      chk("bp_accept_wait", w, 0);
      chk("bp_second_data", data_v[2], 32'h2222_2222);
      chk("bp_second_valid", {31'd0, valid_v[2]}, 32'd1);

      // ---- streaming on channel 1
      for (int i = 1; i <= 8; i++) begin
         send(i, 2'd1, w);
         chk($sformatf("stream_wait%0d", i), w, 0);
         chk($sformatf("stream_data%0d", i), data_v[1], i);
         chk($sformatf("stream_valid%0d", i), {31'd0, valid_v[1]}, 32'd1);
      end
      tick();

      // ---- enable gating
      bus.ready_3 = 1'b0;
      send(32'h5A5A_0003, 2'd3, w);
      bus.enable   = 1'b0;
      bus.data_in  = 32'hDEAD_BEEF;
      bus.select   = 2'd0;
      bus.in_valid = 1'b1;
      bus.ready_3  = 1'b1;
      @(negedge clk);
      chk("en_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("en_drain_valid3", {31'd0, valid_v[3]}, 32'd0);
      chk("en_noload_valid0", {31'd0, valid_v[0]}, 32'd0);
      chk("en_noload_data0", data_v[0], idle(32'hA0A0_0000));
      bus.in_valid = 1'b0;
      bus.enable   = 1'b1;
      tick();

      // ---- unknown select with every channel full and stalled
      bus.ready_0 = 1'b0;
      bus.ready_1 = 1'b0;
      bus.ready_2 = 1'b0;
      bus.ready_3 = 1'b0;
      for (int k = 0; k < 4; k++) send(32'h6000_0000 + k, k[1:0], w);
      bus.data_in  = 32'hFFFF_FFFF;
      bus.select   = 2'bxx;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("xsel_in_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("xsel_valid%0d", k), {31'd0, valid_v[k]}, 32'd1);
         chk($sformatf("xsel_data%0d", k), data_v[k], 32'h6000_0000 + k);
      end
      bus.select = 2'd0;

      // ---- reset mid-run with all channels full
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {28'd0, valid_v}, 32'd0);
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("midrst_data%0d", k), data_v[k], idle(32'd0));
         exp_q[k].delete();
      end
      tick();
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      bus.ready_0  = 1'b1;
      bus.ready_1  = 1'b1;
      bus.ready_2  = 1'b1;
      bus.ready_3  = 1'b1;
      tick();
      send(32'h7777_0001, 2'd0, w);
      chk("post_rst_wait", w, 0);
      repeat (3) tick();
      for (int k = 0; k < 4; k++) chk($sformatf("left_in_q%0d", k), exp_q[k].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
